adc_sample_avg: RTL and testbench

- Downstream and control stage for the SAR ADC core.
- Issues conversion starts at a programmable sample rate and watches the ADC busy/valid handshake to capture each result.
- Accumulates 2^P_AVG_LOG2 conversions and emits their truncated average on a valid/ready stream toward the datapath.
- Flags sample ticks lost because a conversion or output was still pending.

---
 rtl/adc_sample_avg.sv | 152 +++++++++++++++
 tb/tb_adc_sample_avg.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_avg.sv
// adc_sample_avg: sample-rate control and averaging stage behind the SAR ADC core.
// Paces conversion starts from a programmable divider, captures each result from
// the busy/valid handshake, and emits the truncated mean of 2^P_AVG_LOG2 results.
//
// Output handshake: o_data is transferred on every rising i_clk edge where
// o_valid and i_ready are both 1; while o_valid is 1 and i_ready is 0, o_data
// and o_valid hold their values unchanged.
module adc_sample_avg #(
    parameter int P_BIT_CNT  = 8,
    parameter int P_AVG_LOG2 = 2,
    parameter int P_DIV_W    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic [P_DIV_W-1:0]   i_div,
    output logic                 o_adc_start,
    input  logic                 i_adc_busy,
    input  logic [P_BIT_CNT-1:0] i_adc_res,
    input  logic                 i_adc_valid,
    output logic [P_BIT_CNT-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun,
    input  logic                 i_clr_ovr
);

    localparam int ACC_W = P_BIT_CNT + P_AVG_LOG2;
    localparam int CNT_W = (P_AVG_LOG2 > 0) ? P_AVG_LOG2 : 1;
    // Count value held by the last sample of a block, before it is added.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << P_AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_OUT       = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [P_DIV_W-1:0]   div_q, div_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 start_q, start_d;
    logic                 valid_q, valid_d;
    logic [P_BIT_CNT-1:0] data_q, data_d;
    logic                 ovr_q, ovr_d;
    logic                 tick;
    logic [ACC_W-1:0]     sum;

    // Sample-rate divider; held at 0 while disabled or idle so the first tick
    // lands i_div+1 cycles after enable. ">=" keeps a period lowered on the fly
    // from running the counter all the way round.
    always_comb begin
        tick  = i_en && (state_q != S_IDLE) && (div_q >= i_div);
        div_d = div_q + 1'b1;
        if (!i_en || (state_q == S_IDLE) || tick) begin
            div_d = '0;
        end
    end

    // Control FSM: start, capture, accumulate and present the averaged sample.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        sum     = acc_q + ACC_W'(i_adc_res);
        case (state_q)
            S_IDLE: begin
                if (i_en) state_d = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (!i_en) begin
                    // Partial block from before the disable is discarded here.
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (tick) begin
                    start_d = 1'b1;
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // A valid level left over from the previous result is ignored
                // until the core acknowledges the new start with busy.
                if (i_adc_busy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_adc_valid && !i_adc_busy) begin
                    if (cnt_q == CNT_LAST) begin
                        data_d  = P_BIT_CNT'(sum >> P_AVG_LOG2);
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_OUT;
                    end else begin
                        acc_d   = sum;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_WAIT_TICK;
                    end
                end
            end
            S_OUT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = i_en ? S_WAIT_TICK : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky overrun: a tick outside WAIT_TICK is lost; a new loss beats a clear.
    always_comb begin
        ovr_d = ovr_q;
        if (i_clr_ovr) ovr_d = 1'b0;
        if (tick && (state_q != S_WAIT_TICK)) ovr_d = 1'b1;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_adc_start = start_q;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_adc_sample_avg.sv
// Testbench for adc_sample_avg: directed scenarios, a behavioural ADC core and a
// scoreboard of expected averages checked at each output transfer.
module tb_adc_sample_avg;

    logic        clk;
    logic        i_reset;
    logic        i_en;
    logic [15:0] i_div;
    logic        o_adc_start;
    logic        i_adc_busy;
    logic [7:0]  i_adc_res;
    logic        i_adc_valid;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_overrun;
    logic        i_clr_ovr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_results = 0;
    int          n_outputs = 0;
    int          adc_lat  = 3;
    int          adc_phase;
    int          adc_cnt;
    logic [7:0]  exp_q[$];
    logic [7:0]  adc_q[$];
    int          start_cyc[$];

    adc_sample_avg #(.P_BIT_CNT(8), .P_AVG_LOG2(2), .P_DIV_W(16)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_en        (i_en),
        .i_div       (i_div),
        .o_adc_start (o_adc_start),
        .i_adc_busy  (i_adc_busy),
        .i_adc_res   (i_adc_res),
        .i_adc_valid (i_adc_valid),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_overrun   (o_overrun),
        .i_clr_ovr   (i_clr_ovr)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue four ADC results and the truncated mean they must produce.
    task automatic push4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        int s;
        adc_q.push_back(a);
        adc_q.push_back(b);
        adc_q.push_back(c);
        adc_q.push_back(d);
        s = int'(a) + int'(b) + int'(c) + int'(d);
        exp_q.push_back(8'(s >> 2));
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            step(1);
            k++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_starts(input string tag, input int n, input int max_cyc);
        int k = 0;
        while (start_cyc.size() < n && k < max_cyc) begin
            step(1);
            k++;
        end
        check(tag, start_cyc.size(), n);
    endtask

    // Behavioural ADC core: busy starts one cycle after the start pulse (the old
    // valid level lingers meanwhile), result valid after adc_lat busy cycles.
    initial begin
        i_adc_busy  = 1'b0;
        i_adc_valid = 1'b0;
        i_adc_res   = 8'd0;
        adc_phase   = 0;
        adc_cnt     = 0;
        forever begin
            @(negedge clk);
            if (o_adc_start === 1'b1) check("start_while_adc_active", adc_phase, 0);
            case (adc_phase)
                0: if (o_adc_start === 1'b1) adc_phase = 1;
                1: begin
                    i_adc_valid = 1'b0;
                    i_adc_busy  = 1'b1;
                    adc_cnt     = adc_lat;
                    adc_phase   = 2;
                end
                default: begin
                    adc_cnt--;
                    if (adc_cnt <= 0) begin
                        i_adc_busy  = 1'b0;
                        i_adc_valid = 1'b1;
                        if (adc_q.size() > 0) i_adc_res = adc_q.pop_front();
                        else i_adc_res = 8'd0;
                        n_results++;
                        adc_phase = 0;
                    end
                end
            endcase
        end
    end

    // Start pulse monitor
    initial begin
        forever begin
            @(negedge clk);
            if (o_adc_start === 1'b1) start_cyc.push_back(cyc);
        end
    end

    // Scoreboard: compare each transferred output against the expected queue
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                n_outputs++;
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", o_data, e);
                end
            end
        end
    end

    // Directed sequence
    initial begin
        int t0;
        int s0;
        int o0;
        int k;
        logic [7:0] v[8];

        i_reset   = 1'b1;
        i_en      = 1'b0;
        i_div     = 16'd0;
        i_ready   = 1'b1;
        i_clr_ovr = 1'b0;
        step(3);
        check("rst_start", o_adc_start, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_ovr", o_overrun, 0);
        i_reset = 1'b0;
        step(2);

        // Averaging: 10,20,30,41 -> 25, starts 32 cycles apart
        i_div   = 16'd31;
        adc_lat = 5;
        push4(8'd10, 8'd20, 8'd30, 8'd41);
        s0 = start_cyc.size();
        i_en = 1'b1;
        t0 = cyc;
        wait_starts("avg_first_start", s0 + 1, 100);
        if (start_cyc.size() > s0) check("avg_first_delay", start_cyc[s0] - t0, 33);
        wait_drain("avg_drain", 400);
        check("avg_valid_drop", o_valid, 0);
        i_en = 1'b0;
        step(40);
        check("avg_start_count", start_cyc.size(), s0 + 4);
        if (start_cyc.size() >= s0 + 4) begin
            for (int i = 1; i < 4; i++) begin
                check("avg_start_period", start_cyc[s0 + i] - start_cyc[s0 + i - 1], 32);
            end
        end
        check("avg_ovr", o_overrun, 0);

        // Full scale: no wrap of the accumulator
        i_div   = 16'd7;
        adc_lat = 2;
        push4(8'd255, 8'd255, 8'd255, 8'd255);
        i_en = 1'b1;
        wait_drain("full_drain", 200);
        i_en = 1'b0;
        step(20);
        check("full_ovr", o_overrun, 0);

        // Slow conversion: ticks dropped, outputs still correct
        i_div   = 16'd3;
        adc_lat = 10;
        for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(0, 255));
        push4(v[0], v[1], v[2], v[3]);
        push4(v[4], v[5], v[6], v[7]);
        i_en = 1'b1;
        wait_drain("slow_drain", 600);
        i_en = 1'b0;
        step(40);
        check("slow_ovr_set", o_overrun, 1);
        step(10);
        check("slow_ovr_sticky", o_overrun, 1);
        i_clr_ovr = 1'b1;
        step(1);
        i_clr_ovr = 1'b0;
        check("slow_ovr_clr", o_overrun, 0);
        step(5);

        // Backpressure: output held for 200 cycles, no starts meanwhile
        i_div   = 16'd7;
        adc_lat = 2;
        i_ready = 1'b0;
        push4(8'd100, 8'd101, 8'd102, 8'd103);
        push4(8'd7, 8'd9, 8'd11, 8'd13);
        i_en = 1'b1;
        k = 0;
        while (o_valid !== 1'b1 && k < 200) begin
            step(1);
            k++;
        end
        check("bp_valid_rise", o_valid, 1);
        s0 = start_cyc.size();
        step(200);
        check("bp_valid_hold", o_valid, 1);
        check("bp_data_hold", o_data, 101);
        check("bp_no_start", start_cyc.size(), s0);
        check("bp_ovr", o_overrun, 1);
        i_ready = 1'b1;
        step(1);
        check("bp_valid_fall", o_valid, 0);
        wait_drain("bp_resume_drain", 300);
        i_en = 1'b0;
        step(20);
        i_clr_ovr = 1'b1;
        step(1);
        i_clr_ovr = 1'b0;
        check("bp_ovr_clr", o_overrun, 0);

        // Enable handling: partial block discarded, next block starts fresh
        i_div   = 16'd15;
        adc_lat = 3;
        adc_q.push_back(8'd250);
        adc_q.push_back(8'd240);
        push4(8'd4, 8'd8, 8'd12, 8'd17);
        s0 = start_cyc.size();
        o0 = n_outputs;
        k  = n_results;
        i_en = 1'b1;
        t0 = cyc;
        wait_starts("en_first_start", s0 + 1, 100);
        if (start_cyc.size() > s0) check("en_first_delay", start_cyc[s0] - t0, 17);
        t0 = 0;
        while (n_results < k + 2 && t0 < 100) begin
            step(1);
            t0++;
        end
        check("en_two_results", n_results, k + 2);
        step(3);
        i_en = 1'b0;
        step(40);
        check("en_no_output", n_outputs, o0);
        check("en_start_count", start_cyc.size(), s0 + 2);
        check("en_idle", 32'(dut.state_q), 0);
        i_en = 1'b1;
        wait_drain("en_fresh_drain", 400);
        i_en = 1'b0;
        step(20);
        check("en_ovr", o_overrun, 0);

        // Reset during WAIT_DONE with the stale valid level held afterwards
        i_div   = 16'd15;
        adc_lat = 6;
        adc_q.push_back(8'd200);
        i_en = 1'b1;
        k = 0;
        while (i_adc_busy !== 1'b1 && k < 60) begin
            step(1);
            k++;
        end
        check("rst_mid_busy_seen", i_adc_busy, 1);
        step(2);
        i_reset = 1'b1;
        i_en    = 1'b0;
        step(1);
        check("rst_mid_start", o_adc_start, 0);
        check("rst_mid_valid", o_valid, 0);
        check("rst_mid_data", o_data, 0);
        check("rst_mid_ovr", o_overrun, 0);
        step(1);
        i_reset = 1'b0;
        s0 = start_cyc.size();
        o0 = n_outputs;
        step(20);
        check("rst_stale_no_output", n_outputs, o0);
        check("rst_stale_no_start", start_cyc.size(), s0);
        check("rst_stale_idle", 32'(dut.state_q), 0);
        push4(8'd1, 8'd2, 8'd3, 8'd6);
        i_en = 1'b1;
        wait_drain("rst_fresh_drain", 400);
        i_en = 1'b0;
        step(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
